// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: op encodings, FSM states, defaults.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W      = 32;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  // LSB request types; bit 3 = store, bit 2 = unsigned, bits [1:0] = size.
  typedef enum logic [3:0] {
    LS_LB  = 4'b0000,
    LS_LH  = 4'b0001,
    LS_LW  = 4'b0010,
    LS_LBU = 4'b0100,
    LS_LHU = 4'b0101,
    LS_SB  = 4'b1000,
    LS_SH  = 4'b1001,
    LS_SW  = 4'b1010
  } ls_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_FETCH
  } state_e;

  // Number of bytes moved for a given size field.
  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Combinational load result extension: raw little-endian bytes -> sign/zero-extended word.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]        ls_type,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  // Select width and extension from the request type; stores report zero.
  always_comb begin
    ext = raw;
    if (ls_type[3]) begin
      ext = '0;
    end else begin
      case (ls_type[1:0])
        2'b00:   ext = ls_type[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
        2'b01:   ext = ls_type[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        default: ext = raw;
      endcase
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller serving the LSB load/store port and the fetch miss port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              ls_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_val,
  input  logic [3:0]        lsb_type,
  output logic              ls_finished,
  output logic [31:0]       load_val,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_e            state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base_a;
  logic [3:0]        op;
  logic [31:0]       st_data;
  logic [31:0]       rd_buf;
  logic              clr_pend;   // clear seen during a committed store: suppress its pulse
  logic              restart;    // pause hit a read: the read pipeline must restart at byte 0
  logic              mem_wr_q;

  logic [2:0]        nbytes;
  logic [1:0]        cap_idx;
  logic [1:0]        nxt_idx;
  logic [31:0]       rd_next;
  logic [31:0]       ext_val;
  logic              io_block;

  // Per-cycle helpers: byte count, capture merge and IO backpressure.
  always_comb begin
    nbytes   = byte_count(op[1:0]);
    cap_idx  = 2'(cnt - 3'd1);
    nxt_idx  = 2'(cnt + 3'd1);
    rd_next  = rd_buf;
    rd_next[{cap_idx, 3'b000} +: 8] = mem_din;
    io_block = (mem_a >= ADDR_W'(IO_BASE)) && io_buffer_full;
  end

  // Write strobe is gated by pause and by a full IO buffer.
  assign mem_wr = mem_wr_q && rdy_in && !io_block;

  load_ext u_load_ext (
    .ls_type (op),
    .raw     (rd_next),
    .ext     (ext_val)
  );

  // Controller FSM with byte counter and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      base_a      <= '0;
      op          <= 4'd0;
      st_data     <= 32'd0;
      rd_buf      <= 32'd0;
      clr_pend    <= 1'b0;
      restart     <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_a       <= '0;
      mem_dout    <= 8'd0;
      ls_finished <= 1'b0;
      load_val    <= 32'd0;
      if_done     <= 1'b0;
      if_data     <= 32'd0;
    end else if (!rdy_in) begin
      if (state == ST_LOAD || state == ST_FETCH) restart <= 1'b1;
    end else begin
      ls_finished <= 1'b0;
      if_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!clear) begin
            if (ls_enable) begin
              base_a   <= addr;
              op       <= lsb_type;
              st_data  <= store_val;
              cnt      <= 3'd0;
              mem_a    <= addr;
              clr_pend <= 1'b0;
              restart  <= 1'b0;
              if (lsb_type[3]) begin
                state    <= ST_STORE;
                mem_wr_q <= 1'b1;
                mem_dout <= store_val[7:0];
              end else begin
                state    <= ST_LOAD;
              end
            end else if (if_req) begin
              base_a  <= if_addr;
              op      <= LS_LW;
              cnt     <= 3'd0;
              mem_a   <= if_addr;
              restart <= 1'b0;
              state   <= ST_FETCH;
            end
          end
        end

        ST_LOAD, ST_FETCH: begin
          if (clear) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            restart <= 1'b0;
          end else if (restart) begin
            restart <= 1'b0;
            cnt     <= 3'd0;
            mem_a   <= base_a;
          end else if (cnt == nbytes) begin
            state  <= ST_IDLE;
            cnt    <= 3'd0;
            rd_buf <= rd_next;
            if (state == ST_LOAD) begin
              ls_finished <= 1'b1;
              load_val    <= ext_val;
            end else begin
              if_done <= 1'b1;
              if_data <= rd_next;
            end
          end else begin
            if (cnt != 3'd0) rd_buf <= rd_next;
            if ((cnt + 3'd1) < nbytes) mem_a <= base_a + ADDR_W'(cnt + 3'd1);
            cnt <= cnt + 3'd1;
          end
        end

        ST_STORE: begin
          if (clear) clr_pend <= 1'b1;
          if (!io_block) begin
            if (cnt == (nbytes - 3'd1)) begin
              state    <= ST_IDLE;
              cnt      <= 3'd0;
              mem_wr_q <= 1'b0;
              if (!(clear || clr_pend)) begin
                ls_finished <= 1'b1;
                load_val    <= ext_val;
              end
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= base_a + ADDR_W'(cnt + 3'd1);
              mem_dout <= st_data[{nxt_idx, 3'b000} +: 8];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, corner-case sequences, random ops vs model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam logic [3:0] T_LB = 4'b0000, T_LH = 4'b0001, T_LW = 4'b0010, T_LBU = 4'b0100,
                         T_LHU = 4'b0101, T_SB = 4'b1000, T_SH = 4'b1001, T_SW = 4'b1010;
  localparam logic [31:0] IO_B = 32'h0003_0000;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, ls_enable, if_req, io_buffer_full;
  logic [31:0] addr, store_val, if_addr, load_val, if_data, mem_a;
  logic [3:0]  lsb_type;
  logic        ls_finished, if_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int failures = 0;

  // Environment RAM (1 KiB, wraps), IO sink and backdoor preload port.
  logic [7:0]  ram [0:1023];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = 32'd0, pl_data = 32'd0;
  int          wr_cnt = 0, io_cnt = 0;
  logic [7:0]  io_last = 8'd0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .ls_enable(ls_enable), .addr(addr), .store_val(store_val), .lsb_type(lsb_type),
    .ls_finished(ls_finished), .load_val(load_val),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (pl_en) begin
      for (int i = 0; i < 4; i++) ram[10'(pl_addr + 32'(i))] <= pl_data[8*i +: 8];
    end
    if (mem_wr) begin
      if (mem_a >= IO_B) begin
        io_cnt  <= io_cnt + 1;
        io_last <= mem_dout;
      end else begin
        ram[mem_a[9:0]] <= mem_dout;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Waits (bounded) for a done pulse; lat counts cycles after the accept edge.
  task automatic wait_pulse(input bit fetch, output int lat, output logic [31:0] val);
    lat = -1; val = 32'hX;
    for (int k = 0; k < 16; k++) begin
      if (fetch ? if_done : ls_finished) begin
        lat = k; val = fetch ? if_data : load_val;
        break;
      end
      step();
    end
  endtask

  task automatic do_ls(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sv,
                       output int lat, output logic [31:0] val);
    lsb_type = t; addr = a; store_val = sv; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    wait_pulse(1'b0, lat, val);
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic [31:0] addr;
    logic        pre_en;
    logic [31:0] pre_a;
    logic [31:0] pre;
    logic [31:0] sval;
    logic [31:0] exp_val;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [14];
  logic [7:0]  model [0:255];
  logic [3:0]  ops [8];

  initial begin
    int lat, w0, w1, n, exp_lat;
    logic [31:0] val, a, sv, exp_val;
    logic [3:0]  t;
    longint      v;

    vecs[0]  = '{T_LW,  32'h100, 1, 32'h100, 32'h12345678, 0, 32'h12345678, 5};
    vecs[1]  = '{T_LB,  32'h110, 1, 32'h110, 32'h00000080, 0, 32'hFFFFFF80, 2};
    vecs[2]  = '{T_LBU, 32'h110, 0, 0, 0, 0, 32'h00000080, 2};
    vecs[3]  = '{T_LH,  32'h114, 1, 32'h114, 32'h00008001, 0, 32'hFFFF8001, 3};
    vecs[4]  = '{T_LHU, 32'h114, 0, 0, 0, 0, 32'h00008001, 3};
    vecs[5]  = '{T_LH,  32'h121, 1, 32'h120, 32'h00FF7F00, 0, 32'hFFFFFF7F, 3};
    vecs[6]  = '{T_LW,  32'hFFFFFFFE, 1, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, 32'hA1B2C3D4, 5};
    vecs[7]  = '{T_SW,  32'h104, 0, 0, 0, 32'hDEADBEEF, 32'h0, 4};
    vecs[8]  = '{T_LW,  32'h104, 0, 0, 0, 0, 32'hDEADBEEF, 5};
    vecs[9]  = '{T_SH,  32'h130, 1, 32'h130, 32'h55555555, 32'h1234BEEF, 32'h0, 2};
    vecs[10] = '{T_LW,  32'h130, 0, 0, 0, 0, 32'h5555BEEF, 5};
    vecs[11] = '{T_SB,  32'h134, 1, 32'h134, 32'h0, 32'hAABBCC41, 32'h0, 1};
    vecs[12] = '{T_LW,  32'h134, 0, 0, 0, 0, 32'h00000041, 5};
    vecs[13] = '{T_LB,  32'h134, 0, 0, 0, 0, 32'h00000041, 2};
    ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; ls_enable = 1'b0; if_req = 1'b0;
    io_buffer_full = 1'b0; addr = 0; store_val = 0; lsb_type = 0; if_addr = 0;
    #3;
    check("rst_ls_finished", 32'(ls_finished), 0);
    check("rst_load_val", load_val, 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_if_data", if_data, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_dout", 32'(mem_dout), 0);
    step(); step();
    rst_in = 1'b0;
    step();

    // Vector table: latency and result per request.
    foreach (vecs[i]) begin
      if (vecs[i].pre_en) preload(vecs[i].pre_a, vecs[i].pre);
      do_ls(vecs[i].typ, vecs[i].addr, vecs[i].sval, lat, val);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_val", i), val, vecs[i].exp_val);
      step();
    end

    // LW cycle-accurate address sequence and single-cycle pulse.
    lsb_type = T_LW; addr = 32'h100; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) check($sformatf("lw_a_c%0d", k), mem_a, 32'h100 + 32'(k));
      check($sformatf("lw_wr_c%0d", k), 32'(mem_wr), 0);
      check($sformatf("lw_fin_c%0d", k), 32'(ls_finished), (k == 5) ? 1 : 0);
      if (k == 5) check("lw_val", load_val, 32'h12345678);
      if (k == 6) check("lw_val_hold", load_val, 32'h12345678);
      step();
    end

    // SW byte sequence, then SB held in the pulse cycle is accepted back-to-back.
    lsb_type = T_SW; addr = 32'h104; store_val = 32'hDEADBEEF; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_wr_c%0d", k), 32'(mem_wr), 1);
      check($sformatf("sw_a_c%0d", k), mem_a, 32'h104 + 32'(k));
      check($sformatf("sw_d_c%0d", k), 32'(mem_dout), 32'((32'hDEADBEEF >> (8*k)) & 32'hFF));
      check($sformatf("sw_fin_c%0d", k), 32'(ls_finished), 0);
      step();
    end
    check("sw_fin_c4", 32'(ls_finished), 1);
    check("sw_wr_c4", 32'(mem_wr), 0);
    lsb_type = T_SB; addr = 32'h140; store_val = 32'h00000077; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    check("b2b_sb_wr", 32'(mem_wr), 1);
    check("b2b_sb_a", mem_a, 32'h140);
    check("b2b_sb_d", 32'(mem_dout), 32'h77);
    step();
    check("b2b_sb_fin", 32'(ls_finished), 1);
    step();

    // Arbitration: LSB first, then fetch starts after the LSB pulse.
    preload(32'h0, 32'h00000513);
    lsb_type = T_LB; addr = 32'h110; ls_enable = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    step();
    ls_enable = 1'b0;
    check("arb_lsb_a", mem_a, 32'h110);
    wait_pulse(1'b0, lat, val);
    check("arb_lsb_lat", 32'(lat), 2);
    step();
    if_req = 1'b0;
    check("arb_fetch_a", mem_a, 32'h0);
    wait_pulse(1'b1, lat, val);
    check("arb_fetch_lat", 32'(lat), 5);
    check("arb_fetch_data", val, 32'h00000513);
    step();
    check("arb_if_done_once", 32'(if_done), 0);
    check("arb_if_data_hold", if_data, 32'h00000513);

    // IO backpressure: three blocked cycles then a single write.
    io_buffer_full = 1'b1; w0 = io_cnt;
    lsb_type = T_SB; addr = IO_B; store_val = 32'h00000041; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("io_blk_wr_c%0d", k), 32'(mem_wr), 0);
      check($sformatf("io_blk_fin_c%0d", k), 32'(ls_finished), 0);
      step();
    end
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", 32'(mem_wr), 1);
    check("io_d", 32'(mem_dout), 32'h41);
    step();
    check("io_fin", 32'(ls_finished), 1);
    check("io_writes", 32'(io_cnt - w0), 1);
    check("io_byte", 32'(io_last), 32'h41);
    step();

    // Clear in LW cycle 2: aborted, no pulse.
    lsb_type = T_LW; addr = 32'h100; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_pulse(1'b0, lat, val);
    check("clr_lw_no_pulse", 32'(lat), 32'hFFFFFFFF);

    // Clear in SW cycle 1: all bytes committed, pulse suppressed.
    w0 = wr_cnt;
    lsb_type = T_SW; addr = 32'h150; store_val = 32'hCAFEF00D; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_pulse(1'b0, lat, val);
    check("clr_sw_no_pulse", 32'(lat), 32'hFFFFFFFF);
    check("clr_sw_writes", 32'(wr_cnt - w0), 4);
    do_ls(T_LW, 32'h150, 0, lat, val);
    check("clr_sw_readback", val, 32'hCAFEF00D);
    step();

    // Request on the clear edge in IDLE is dropped.
    w0 = wr_cnt;
    lsb_type = T_SB; addr = 32'h160; store_val = 32'h99; ls_enable = 1'b1; clear = 1'b1;
    step();
    ls_enable = 1'b0; clear = 1'b0;
    wait_pulse(1'b0, lat, val);
    check("clr_idle_no_pulse", 32'(lat), 32'hFFFFFFFF);
    check("clr_idle_no_write", 32'(wr_cnt - w0), 0);

    // Pause mid-LW restarts the read; pause mid-SW holds writes off and resumes.
    lsb_type = T_LW; addr = 32'h100; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    step();
    rdy_in = 1'b0;
    step(); step();
    rdy_in = 1'b1;
    wait_pulse(1'b0, lat, val);
    check("pause_lw_val", val, 32'h12345678);
    check("pause_lw_seen", 32'(lat >= 0), 1);
    step();
    lsb_type = T_SW; addr = 32'h170; store_val = 32'h0BADF00D; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    step();
    rdy_in = 1'b0;
    #1;
    check("pause_sw_wr", 32'(mem_wr), 0);
    step(); step();
    rdy_in = 1'b1;
    wait_pulse(1'b0, lat, val);
    check("pause_sw_seen", 32'(lat >= 0), 1);
    do_ls(T_LW, 32'h170, 0, lat, val);
    check("pause_sw_readback", val, 32'h0BADF00D);
    step();

    // Asynchronous reset mid-store clears outputs immediately.
    lsb_type = T_SW; addr = 32'h180; store_val = 32'h11223344; ls_enable = 1'b1;
    step();
    ls_enable = 1'b0;
    step();
    rst_in = 1'b1;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 0);
    check("arst_mem_a", mem_a, 0);
    check("arst_mem_dout", 32'(mem_dout), 0);
    check("arst_load_val", load_val, 0);
    check("arst_if_data", if_data, 0);
    check("arst_fin", 32'(ls_finished | if_done), 0);
    step();
    rst_in = 1'b0;
    step();

    // Random ops against a byte-array model of region 0x200..0x2FF.
    for (int i = 0; i < 64; i++) begin
      a = $urandom;
      preload(32'h200 + 32'(4*i), a);
      for (int b = 0; b < 4; b++) model[4*i+b] = a[8*b +: 8];
    end
    for (int i = 0; i < 80; i++) begin
      t  = ops[$urandom_range(0, 7)];
      w1 = $urandom_range(0, 251);
      a  = 32'h200 + 32'(w1);
      sv = $urandom;
      n  = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
      if (t[3]) begin
        for (int b = 0; b < n; b++) model[w1+b] = sv[8*b +: 8];
        exp_val = 0; exp_lat = n;
      end else begin
        v = 0;
        for (int b = 0; b < n; b++) v += longint'(model[w1+b]) << (8*b);
        if (!t[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        exp_val = 32'(v); exp_lat = n + 1;
      end
      do_ls(t, a, sv, lat, val);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
      check($sformatf("rnd%0d_val", i), val, exp_val);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
